// File: rtl/range_match_pkg.sv
// Shared types and helpers for the pipelined range matcher.
package range_match_pkg;

    // Widest key the rule table can hold; narrower keys use the low bits.
    localparam int unsigned MAX_KEY_W = 64;

    typedef enum logic [1:0] {
        CMP_EQ = 2'd0,
        CMP_LT = 2'd1,
        CMP_GT = 2'd2
    } cmp_t;

    typedef struct packed {
        logic [MAX_KEY_W-1:0] lb;
        logic [MAX_KEY_W-1:0] ub;
        logic                 en;
    } rule_t;

    function automatic int unsigned nstages(int unsigned key_w, int unsigned chunk_w);
        return key_w / chunk_w;
    endfunction

    // Once a higher chunk has decided the ordering, lower chunks cannot change it.
    function automatic cmp_t cmp_next(cmp_t st, logic gt, logic lt);
        if (st != CMP_EQ) return st;
        if (gt) return CMP_GT;
        if (lt) return CMP_LT;
        return CMP_EQ;
    endfunction

endpackage

// File: rtl/range_match_stage.sv
// One pipeline stage: compares one key chunk against every rule's bound chunks
// and registers the key, valid flag and per-rule compare state.
module range_match_stage
    import range_match_pkg::*;
#(
    parameter int unsigned KEY_W     = 16,
    parameter int unsigned CHUNK_W   = 4,
    parameter int unsigned NUM_RULES = 8,
    parameter int unsigned STAGE     = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_adv,
    input  logic                           i_valid,
    input  logic [KEY_W-1:0]               i_key,
    input  logic [2*NUM_RULES-1:0]         i_lb_st,
    input  logic [2*NUM_RULES-1:0]         i_ub_st,
    input  logic [NUM_RULES*CHUNK_W-1:0]   i_lb_chunk,
    input  logic [NUM_RULES*CHUNK_W-1:0]   i_ub_chunk,
    output logic                           o_valid,
    output logic [KEY_W-1:0]               o_key,
    output logic [2*NUM_RULES-1:0]         o_lb_st,
    output logic [2*NUM_RULES-1:0]         o_ub_st
);

    localparam int unsigned MSB = KEY_W - 1 - STAGE * CHUNK_W;

    logic [CHUNK_W-1:0]     w_chunk;
    logic [2*NUM_RULES-1:0] w_lb_st_d;
    logic [2*NUM_RULES-1:0] w_ub_st_d;

    logic                   r_valid;
    logic [KEY_W-1:0]       r_key;
    logic [2*NUM_RULES-1:0] r_lb_st;
    logic [2*NUM_RULES-1:0] r_ub_st;

    assign w_chunk = i_key[MSB -: CHUNK_W];

    // Refine each rule's lower/upper compare state with this stage's chunk.
    always_comb begin
        w_lb_st_d = '0;
        w_ub_st_d = '0;
        for (int r = 0; r < NUM_RULES; r++) begin
            w_lb_st_d[2*r +: 2] = cmp_next(cmp_t'(i_lb_st[2*r +: 2]),
                                           w_chunk > i_lb_chunk[r*CHUNK_W +: CHUNK_W],
                                           w_chunk < i_lb_chunk[r*CHUNK_W +: CHUNK_W]);
            w_ub_st_d[2*r +: 2] = cmp_next(cmp_t'(i_ub_st[2*r +: 2]),
                                           w_chunk > i_ub_chunk[r*CHUNK_W +: CHUNK_W],
                                           w_chunk < i_ub_chunk[r*CHUNK_W +: CHUNK_W]);
        end
    end

    // Stage register; holds its contents whenever the pipeline is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_key   <= '0;
            r_lb_st <= '0;
            r_ub_st <= '0;
        end else if (i_adv) begin
            r_valid <= i_valid;
            r_key   <= i_key;
            r_lb_st <= w_lb_st_d;
            r_ub_st <= w_ub_st_d;
        end
    end

    assign o_valid = r_valid;
    assign o_key   = r_key;
    assign o_lb_st = r_lb_st;
    assign o_ub_st = r_ub_st;

endmodule

// File: rtl/range_match_pipeline.sv
// Pipelined range classifier: one chunk per stage, MSB first, with a
// double-buffered rule table whose commit waits for the pipeline to drain.
module range_match_pipeline
    import range_match_pkg::*;
#(
    parameter int unsigned KEY_W     = 16,
    parameter int unsigned CHUNK_W   = 4,
    parameter int unsigned NUM_RULES = 8,
    parameter int unsigned IDX_W     = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [KEY_W-1:0]     in_key,
    input  logic                 cfg_we,
    input  logic [IDX_W-1:0]     cfg_idx,
    input  logic [KEY_W-1:0]     cfg_lb,
    input  logic [KEY_W-1:0]     cfg_ub,
    input  logic                 cfg_en,
    input  logic                 cfg_commit,
    output logic                 cfg_busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NUM_RULES-1:0] out_match,
    output logic                 out_hit,
    output logic [IDX_W-1:0]     out_idx
);

    localparam int unsigned NSTAGES = nstages(KEY_W, CHUNK_W);

    if ((KEY_W % CHUNK_W) != 0 || KEY_W > MAX_KEY_W) begin : g_param_err
        $error("range_match_pipeline: KEY_W must be a multiple of CHUNK_W and <= MAX_KEY_W");
    end

    typedef enum logic [0:0] {StIdle, StDrain} state_e;

    state_e                  r_state;
    state_e                  w_state_d;
    logic                    w_copy;

    rule_t [NUM_RULES-1:0]   r_shadow;
    rule_t [NUM_RULES-1:0]   r_active;
    rule_t [NUM_RULES-1:0]   w_shadow_d;
    rule_t                   w_cfg_rule;

    logic                    w_adv;
    logic                    w_any_valid;
    logic [NSTAGES:0]        w_valid;
    logic [KEY_W-1:0]        w_key   [NSTAGES+1];
    logic [2*NUM_RULES-1:0]  w_lb_st [NSTAGES+1];
    logic [2*NUM_RULES-1:0]  w_ub_st [NSTAGES+1];
    logic                    w_unused;

    // Advance / accept control.
    assign w_adv       = ~out_valid | out_ready;
    assign in_ready    = w_adv & (r_state == StIdle);
    assign w_any_valid = |w_valid[NSTAGES:1];
    assign cfg_busy    = (r_state == StDrain);

    // Stage 0 inputs: every rule starts undecided (CMP_EQ encodes as zero).
    assign w_valid[0] = in_valid & in_ready;
    assign w_key[0]   = in_key;
    assign w_lb_st[0] = '0;
    assign w_ub_st[0] = '0;

    for (genvar g = 0; g < NSTAGES; g++) begin : g_stage
        logic [NUM_RULES*CHUNK_W-1:0] w_lb_chunk;
        logic [NUM_RULES*CHUNK_W-1:0] w_ub_chunk;

        // Slice this stage's chunk out of every active bound.
        always_comb begin
            w_lb_chunk = '0;
            w_ub_chunk = '0;
            for (int r = 0; r < NUM_RULES; r++) begin
                w_lb_chunk[r*CHUNK_W +: CHUNK_W] = r_active[r].lb[KEY_W-1-g*CHUNK_W -: CHUNK_W];
                w_ub_chunk[r*CHUNK_W +: CHUNK_W] = r_active[r].ub[KEY_W-1-g*CHUNK_W -: CHUNK_W];
            end
        end

        range_match_stage #(
            .KEY_W    (KEY_W),
            .CHUNK_W  (CHUNK_W),
            .NUM_RULES(NUM_RULES),
            .STAGE    (g)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .i_adv     (w_adv),
            .i_valid   (w_valid[g]),
            .i_key     (w_key[g]),
            .i_lb_st   (w_lb_st[g]),
            .i_ub_st   (w_ub_st[g]),
            .i_lb_chunk(w_lb_chunk),
            .i_ub_chunk(w_ub_chunk),
            .o_valid   (w_valid[g+1]),
            .o_key     (w_key[g+1]),
            .o_lb_st   (w_lb_st[g+1]),
            .o_ub_st   (w_ub_st[g+1])
        );
    end

    // Final stage holds the result; the active table cannot change under it
    // because a commit only copies once every stage is empty.
    assign out_valid = w_valid[NSTAGES];

    // Resolve per-rule match from the final compare state.
    always_comb begin
        out_match = '0;
        for (int r = 0; r < NUM_RULES; r++) begin
            out_match[r] = out_valid & r_active[r].en
                         & (w_lb_st[NSTAGES][2*r +: 2] != CMP_LT)
                         & (w_ub_st[NSTAGES][2*r +: 2] != CMP_GT);
        end
    end

    assign out_hit = |out_match;

    // Lowest-index hit wins.
    always_comb begin
        out_idx = '0;
        for (int r = int'(NUM_RULES) - 1; r >= 0; r--) begin
            if (out_match[r]) out_idx = IDX_W'(r);
        end
    end

    // Shadow table with this cycle's write applied, so a copy picks it up.
    always_comb begin
        w_cfg_rule                = '0;
        w_cfg_rule.lb[KEY_W-1:0]  = cfg_lb;
        w_cfg_rule.ub[KEY_W-1:0]  = cfg_ub;
        w_cfg_rule.en             = cfg_en;
        w_shadow_d                = r_shadow;
        if (cfg_we) w_shadow_d[cfg_idx] = w_cfg_rule;
    end

    // Commit FSM next state: wait for an empty pipeline, then copy.
    always_comb begin
        w_state_d = r_state;
        w_copy    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (cfg_commit) w_state_d = StDrain;
            end
            StDrain: begin
                if (!w_any_valid) begin
                    w_copy    = 1'b1;
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Commit FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= StIdle;
        else     r_state <= w_state_d;
    end

    // Shadow and active rule tables.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= '0;
            r_active <= '0;
        end else begin
            r_shadow <= w_shadow_d;
            if (w_copy) r_active <= w_shadow_d;
        end
    end

    // Bound bits above KEY_W and the last stage's key copy have no consumer.
    assign w_unused = ^{r_active, w_key[NSTAGES]};

endmodule

// File: tb/tb_range_match_pipeline.sv
// Bench for range_match_pipeline: vector tables plus hand-written sequences,
// results checked against an expected-value queue.
module tb_range_match_pipeline;

    localparam int KW = 16;
    localparam int NR = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [KW-1:0] in_key = '0;
    logic          cfg_we = 1'b0;
    logic [IW-1:0] cfg_idx = '0;
    logic [KW-1:0] cfg_lb = '0;
    logic [KW-1:0] cfg_ub = '0;
    logic          cfg_en = 1'b0;
    logic          cfg_commit = 1'b0;
    logic          cfg_busy;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [NR-1:0] out_match;
    logic          out_hit;
    logic [IW-1:0] out_idx;

    always #5 clk = ~clk;

    range_match_pipeline #(
        .KEY_W    (KW),
        .CHUNK_W  (4),
        .NUM_RULES(NR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_key    (in_key),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_lb    (cfg_lb),
        .cfg_ub    (cfg_ub),
        .cfg_en    (cfg_en),
        .cfg_commit(cfg_commit),
        .cfg_busy  (cfg_busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_match (out_match),
        .out_hit   (out_hit),
        .out_idx   (out_idx)
    );

    typedef struct packed {
        logic [KW-1:0] key;
        logic [NR-1:0] exp;
    } vec_t;

    vec_t          tab_a [5];
    vec_t          tab_b [7];
    logic [NR-1:0] exp_q [$];
    logic [NR-1:0] cur_exp = '0;
    logic [NR-1:0] mon_e;
    int            n_cmp = 0;
    int            n_fail = 0;

    // Reference tables: s_* mirrors the shadow, a_* the active table.
    logic [KW-1:0] s_lb [NR];
    logic [KW-1:0] s_ub [NR];
    logic          s_en [NR];
    logic [KW-1:0] a_lb [NR];
    logic [KW-1:0] a_ub [NR];
    logic          a_en [NR];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NR-1:0] model(input logic [KW-1:0] k);
        logic [NR-1:0] m;
        for (int r = 0; r < NR; r++) m[r] = a_en[r] && (k >= a_lb[r]) && (k <= a_ub[r]);
        return m;
    endfunction

    function automatic logic [IW-1:0] idx_of(input logic [NR-1:0] m);
        logic [IW-1:0] ix;
        ix = '0;
        for (int r = NR - 1; r >= 0; r--) if (m[r]) ix = IW'(r);
        return ix;
    endfunction

    task automatic clear_model();
        for (int r = 0; r < NR; r++) begin
            s_lb[r] = '0; s_ub[r] = '0; s_en[r] = 1'b0;
            a_lb[r] = '0; a_ub[r] = '0; a_en[r] = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: push on accept, compare the head every cycle out_valid is high.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) exp_q.push_back(cur_exp);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    mon_e = exp_q[0];
                    check("out_match", 32'(out_match), 32'(mon_e));
                    check("out_hit", 32'(out_hit), 32'(|mon_e));
                    check("out_idx", 32'(out_idx), 32'(idx_of(mon_e)));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [KW-1:0] k, input logic [NR-1:0] e);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_key   = k;
        cur_exp  = e;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) check("send_accepted", 32'(acc), 32'd1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && (exp_q.size() != 0 || out_valid); i++) tick();
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic write_rule(input int idx, input logic [KW-1:0] lb, input logic [KW-1:0] ub,
                              input logic en);
        cfg_we  = 1'b1;
        cfg_idx = IW'(idx);
        cfg_lb  = lb;
        cfg_ub  = ub;
        cfg_en  = en;
        tick();
        cfg_we  = 1'b0;
        s_lb[idx] = lb; s_ub[idx] = ub; s_en[idx] = en;
    endtask

    // Commit into an already-empty pipeline: busy for exactly one cycle.
    task automatic commit_empty();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        check("commit_busy_set", 32'(cfg_busy), 32'd1);
        check("commit_in_ready_low", 32'(in_ready), 32'd0);
        tick();
        check("commit_busy_clear", 32'(cfg_busy), 32'd0);
        for (int r = 0; r < NR; r++) begin
            a_lb[r] = s_lb[r]; a_ub[r] = s_ub[r]; a_en[r] = s_en[r];
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit seen_stall;
        tab_a[0] = '{key: 16'h1234, exp: 4'b0001};
        tab_a[1] = '{key: 16'h0FFF, exp: 4'b0000};
        tab_a[2] = '{key: 16'h1000, exp: 4'b0001};
        tab_a[3] = '{key: 16'h1FFF, exp: 4'b0001};
        tab_a[4] = '{key: 16'h2000, exp: 4'b0000};
        tab_b[0] = '{key: 16'h1250, exp: 4'b0111};
        tab_b[1] = '{key: 16'h4800, exp: 4'b0100};
        tab_b[2] = '{key: 16'h5000, exp: 4'b0100};
        tab_b[3] = '{key: 16'h4000, exp: 4'b0100};
        tab_b[4] = '{key: 16'h12FF, exp: 4'b0111};
        tab_b[5] = '{key: 16'h1300, exp: 4'b0101};
        tab_b[6] = '{key: 16'h11FF, exp: 4'b0101};
        clear_model();

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_match", 32'(out_match), 32'd0);
        check("rst_out_hit", 32'(out_hit), 32'd0);
        check("rst_out_idx", 32'(out_idx), 32'd0);
        check("rst_cfg_busy", 32'(cfg_busy), 32'd0);
        rst = 1'b0;
        tick();

        // Single rule, single key, exact latency.
        write_rule(0, 16'h1000, 16'h1FFF, 1'b1);
        commit_empty();
        send(tab_a[0].key, tab_a[0].exp);
        check("lat_c1", 32'(out_valid), 32'd0);
        tick();
        check("lat_c2", 32'(out_valid), 32'd0);
        tick();
        check("lat_c3", 32'(out_valid), 32'd0);
        tick();
        check("lat_c4", 32'(out_valid), 32'd1);
        wait_drain();

        // Boundaries of rule 0, back-to-back.
        for (int i = 1; i < 5; i++) send(tab_a[i].key, tab_a[i].exp);
        wait_drain();

        // Overlapping rules, a full-range rule and an inverted rule.
        write_rule(1, 16'h1200, 16'h12FF, 1'b1);
        write_rule(2, 16'h0000, 16'hFFFF, 1'b1);
        write_rule(3, 16'h5000, 16'h4000, 1'b1);
        commit_empty();
        for (int i = 0; i < 7; i++) send(tab_b[i].key, tab_b[i].exp);
        wait_drain();

        // Output stall while streaming.
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(16'h0E80 + 16'(i) * 16'h0400, model(16'h0E80 + 16'(i) * 16'h0400));
                end
            end
            begin
                seen_stall = 1'b0;
                repeat (6) begin
                    @(negedge clk);
                    if (!in_ready) seen_stall = 1'b1;
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        check("stall_in_ready_dropped", 32'(seen_stall), 32'd1);
        wait_drain();

        // Commit with keys in flight: they keep the old table.
        for (int i = 0; i < 3; i++) send(16'h1500, model(16'h1500));
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_lb = 16'h1000; cfg_ub = 16'h1FFF; cfg_en = 1'b0;
        cfg_commit = 1'b1;
        tick();
        cfg_we = 1'b0;
        cfg_commit = 1'b0;
        s_en[0] = 1'b0;
        check("drain_busy_set", 32'(cfg_busy), 32'd1);
        check("drain_in_ready_low", 32'(in_ready), 32'd0);
        // Shadow write plus a repeated commit while draining.
        cfg_we = 1'b1; cfg_idx = 2'd3; cfg_lb = 16'h1500; cfg_ub = 16'h1500; cfg_en = 1'b1;
        cfg_commit = 1'b1;
        tick();
        cfg_we = 1'b0;
        cfg_commit = 1'b0;
        s_lb[3] = 16'h1500; s_ub[3] = 16'h1500; s_en[3] = 1'b1;
        for (int i = 0; i < 50 && cfg_busy; i++) begin
            check("busy_in_ready_low", 32'(in_ready), 32'd0);
            tick();
        end
        check("drain_busy_clear", 32'(cfg_busy), 32'd0);
        check("drain_results_out", 32'(exp_q.size()), 32'd0);
        for (int r = 0; r < NR; r++) begin
            a_lb[r] = s_lb[r]; a_ub[r] = s_ub[r]; a_en[r] = s_en[r];
        end
        send(16'h1500, model(16'h1500));
        wait_drain();

        // Asynchronous reset mid-stream with a commit pending.
        out_ready = 1'b0;
        send(16'h1234, model(16'h1234));
        send(16'h2345, model(16'h2345));
        for (int i = 0; i < 20 && !out_valid; i++) tick();
        check("pre_rst_out_valid", 32'(out_valid), 32'd1);
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        check("pre_rst_busy", 32'(cfg_busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_cfg_busy", 32'(cfg_busy), 32'd0);
        check("async_rst_out_hit", 32'(out_hit), 32'd0);
        check("async_rst_out_match", 32'(out_match), 32'd0);
        exp_q.delete();
        clear_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        send(16'h1234, model(16'h1234));
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
